// File: rtl/quant_pkg.sv
`default_nettype none
// ============================================================================
// Module      : quant_pkg
// Description : Shared precision encoding, clamp bounds and the saturating
//               clamp helper used by the requantisation back end and by
//               mac_unit users.
// Revision    : 1.0 - initial release
// ============================================================================
package quant_pkg;

    // Precision encoding shared with the MAC array. Code 3 is treated as BIN.
    typedef enum logic [1:0] {
        PREC_INT8 = 2'd0,
        PREC_INT4 = 2'd1,
        PREC_BIN  = 2'd2
    } prec_e;

    localparam longint INT8_MIN = -128;
    localparam longint INT8_MAX = 127;
    localparam longint INT4_MIN = -8;
    localparam longint INT4_MAX = 7;

    // Clamp a rounded, shifted value to the target precision.
    // INT8/INT4 return the two's-complement result in the low bits.
    // BIN returns 1 in bit 0 when the value is non-negative.
    function automatic logic [7:0] sat_clamp(input logic signed [63:0] v,
                                             input logic [1:0]         p);
        logic [7:0] res;
        res = 8'h00;
        if (p == PREC_INT8) begin
            if (v > INT8_MAX)      res = 8'h7F;
            else if (v < INT8_MIN) res = 8'h80;
            else                   res = v[7:0];
        end else if (p == PREC_INT4) begin
            if (v > INT4_MAX)      res = 8'h07;
            else if (v < INT4_MIN) res = 8'hF8;
            else                   res = v[7:0];
        end else begin
            res = {7'b0, ~v[63]};
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/requant_stage.sv
`default_nettype none
// ============================================================================
// Module      : requant_stage
// Description : Pipeline stages 1 and 2 of the requantiser. S1 multiplies the
//               signed accumulator by the unsigned scale; S2 rounds (half
//               toward +inf), arithmetic-shifts and clamps to the precision.
//               Both stages advance only when en is high.
//   Ports: clk, rst         clock / synchronous active-high reset
//          en               global pipeline advance
//          in_valid/acc/last  element entering S1
//          scale_m          multiplier used by S1
//          shift, prec      shift/precision used by S2
//          s2_valid/val/last  S2 result presented to the packer
//          sat_count        saturation counter
//   Optional feature: REQUANT_SAT_CNT_EN enables the saturation counter;
//   otherwise sat_count is tied to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module requant_stage
    import quant_pkg::*;
#(
    parameter int ACC_W   = 32,
    parameter int SCALE_W = 16,
    parameter int SHIFT_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               in_valid,
    input  logic [ACC_W-1:0]   in_acc,
    input  logic               in_last,
    input  logic [SCALE_W-1:0] scale_m,
    input  logic [SHIFT_W-1:0] shift,
    input  logic [1:0]         prec,
    output logic               s2_valid,
    output logic [7:0]         s2_val,
    output logic               s2_last,
    output logic [15:0]        sat_count
);

    localparam int P_W = ACC_W + SCALE_W + 1;

    logic signed [P_W-1:0] w_acc_x;
    logic signed [P_W-1:0] w_scl_x;
    logic signed [P_W-1:0] w_prod;
    logic signed [P_W-1:0] w_rnd;
    logic signed [P_W-1:0] w_r;
    logic signed [63:0]    w_r64;
    logic [7:0]            w_val;

    logic                  r_v1;
    logic signed [P_W-1:0] r_p;
    logic                  r_last1;
    logic                  r_v2;
    logic [7:0]            r_val;
    logic                  r_last2;

    // Operands are widened to the full product width so the product is exact.
    assign w_acc_x = {{(P_W-ACC_W){in_acc[ACC_W-1]}}, in_acc};
    assign w_scl_x = {{(P_W-SCALE_W){1'b0}}, scale_m};
    assign w_prod  = w_acc_x * w_scl_x;

    // Adding half an LSB before the arithmetic shift rounds half toward +inf.
    assign w_rnd = (shift == '0) ? '0
                 : ({{(P_W-1){1'b0}}, 1'b1} << (shift - 1'b1));
    assign w_r   = (r_p + w_rnd) >>> shift;
    assign w_r64 = {{(64-P_W){w_r[P_W-1]}}, w_r};
    assign w_val = sat_clamp(w_r64, prec);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v1    <= 1'b0;
            r_p     <= '0;
            r_last1 <= 1'b0;
            r_v2    <= 1'b0;
            r_val   <= '0;
            r_last2 <= 1'b0;
        end else if (en) begin
            r_v1    <= in_valid;
            r_p     <= w_prod;
            r_last1 <= in_last;
            r_v2    <= r_v1;
            r_val   <= w_val;
            r_last2 <= r_last1;
        end
    end

    assign s2_valid = r_v2;
    assign s2_val   = r_val;
    assign s2_last  = r_last2;

`ifdef REQUANT_SAT_CNT_EN
    logic        w_sat;
    logic        r_sat;
    logic [15:0] r_sat_cnt;

    assign w_sat = ((prec == PREC_INT8) && ((w_r64 > INT8_MAX) || (w_r64 < INT8_MIN)))
                || ((prec == PREC_INT4) && ((w_r64 > INT4_MAX) || (w_r64 < INT4_MIN)));

    // Counted as the element leaves S2 so a stalled element is counted once.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sat     <= 1'b0;
            r_sat_cnt <= 16'd0;
        end else if (en) begin
            r_sat <= w_sat;
            if (r_v2 && r_sat && (r_sat_cnt != 16'hFFFF))
                r_sat_cnt <= r_sat_cnt + 16'd1;
        end
    end

    assign sat_count = r_sat_cnt;
`else
    assign sat_count = 16'd0;
`endif

endmodule
`default_nettype wire

// File: rtl/requant_packer.sv
`default_nettype none
// ============================================================================
// Module      : requant_packer
// Description : Requantisation back end. Scales, rounds, shifts and clamps
//               signed accumulator elements to INT8/INT4/BIN and packs them
//               into bytes (1, 2 or 8 elements per byte). 3-stage pipeline,
//               valid/ready on both sides.
//   Ports: clk, rst                 clock / synchronous active-high reset
//          prec, scale_m, shift     configuration, latched at packet start
//          in_valid/ready/acc/last  accumulator element stream
//          out_valid/ready/data/last packed byte stream
//          busy                     packet in progress
//          sat_count                saturation counter
//   Optional feature: REQUANT_SAT_CNT_EN enables the saturation counter.
// Revision    : 1.0 - initial release
// ============================================================================
module requant_packer
    import quant_pkg::*;
#(
    parameter int ACC_W   = 32,
    parameter int SCALE_W = 16,
    parameter int SHIFT_W = 5,
    parameter int OUT_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         prec,
    input  logic [SCALE_W-1:0] scale_m,
    input  logic [SHIFT_W-1:0] shift,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [ACC_W-1:0]   in_acc,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [OUT_W-1:0]   out_data,
    output logic               out_last,
    output logic               busy,
    output logic [15:0]        sat_count
);

    logic               w_en;
    logic               w_accept;
    logic [SCALE_W-1:0] w_scale;

    logic               r_busy;
    logic [1:0]         r_cfg_prec;
    logic [SCALE_W-1:0] r_cfg_scale;
    logic [SHIFT_W-1:0] r_cfg_shift;

    logic               w_s2_valid;
    logic [7:0]         w_s2_val;
    logic               w_s2_last;

    logic [OUT_W-1:0]   w_field;
    logic [OUT_W-1:0]   w_byte;
    logic [2:0]         w_step;
    logic               w_full;

    logic               r_out_valid, w_out_valid_nxt;
    logic [OUT_W-1:0]   r_out_data,  w_out_data_nxt;
    logic               r_out_last,  w_out_last_nxt;
    logic [2:0]         r_pos,       w_pos_nxt;
    logic [OUT_W-1:0]   r_part,      w_part_nxt;

    assign w_en     = !r_out_valid || out_ready;
    assign in_ready = w_en;
    assign w_accept = in_valid && w_en;

    // The first element of a packet is multiplied in the cycle it is
    // accepted, before the latched copy exists, so it uses the live scale.
    // S2 runs a cycle later and always sees the latched shift/precision.
    assign w_scale = r_busy ? r_cfg_scale : scale_m;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy      <= 1'b0;
            r_cfg_prec  <= 2'd0;
            r_cfg_scale <= '0;
            r_cfg_shift <= '0;
        end else if (w_accept && !r_busy) begin
            r_busy      <= 1'b1;
            r_cfg_prec  <= prec;
            r_cfg_scale <= scale_m;
            r_cfg_shift <= shift;
        end else if (r_out_valid && out_ready && r_out_last) begin
            r_busy      <= 1'b0;
        end
    end

    requant_stage #(
        .ACC_W   (ACC_W),
        .SCALE_W (SCALE_W),
        .SHIFT_W (SHIFT_W)
    ) u_requant_stage (
        .clk       (clk),
        .rst       (rst),
        .en        (w_en),
        .in_valid  (in_valid),
        .in_acc    (in_acc),
        .in_last   (in_last),
        .scale_m   (w_scale),
        .shift     (r_cfg_shift),
        .prec      (r_cfg_prec),
        .s2_valid  (w_s2_valid),
        .s2_val    (w_s2_val),
        .s2_last   (w_s2_last),
        .sat_count (sat_count)
    );

    // Packer: each element is a field of 8, 4 or 1 bits OR-ed in at r_pos.
    always_comb begin
        w_field = {{(OUT_W-1){1'b0}}, w_s2_val[0]};
        w_step  = 3'd1;
        w_full  = (r_pos == 3'd7);
        if (r_cfg_prec == PREC_INT8) begin
            w_field = w_s2_val;
            w_step  = 3'd0;
            w_full  = 1'b1;
        end else if (r_cfg_prec == PREC_INT4) begin
            w_field = {4'b0, w_s2_val[3:0]};
            w_step  = 3'd4;
            w_full  = (r_pos == 3'd4);
        end
    end

    assign w_byte = r_part | (w_field << r_pos);

    always_comb begin
        w_out_valid_nxt = r_out_valid;
        w_out_data_nxt  = r_out_data;
        w_out_last_nxt  = r_out_last;
        w_pos_nxt       = r_pos;
        w_part_nxt      = r_part;
        if (w_en) begin
            w_out_valid_nxt = 1'b0;
            if (w_s2_valid) begin
                if (w_full || w_s2_last) begin
                    // Unused upper bits of a short final byte stay zero.
                    w_out_valid_nxt = 1'b1;
                    w_out_data_nxt  = w_byte;
                    w_out_last_nxt  = w_s2_last;
                    w_pos_nxt       = 3'd0;
                    w_part_nxt      = '0;
                end else begin
                    w_part_nxt      = w_byte;
                    w_pos_nxt       = r_pos + w_step;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            r_pos       <= 3'd0;
            r_part      <= '0;
        end else begin
            r_out_valid <= w_out_valid_nxt;
            r_out_data  <= w_out_data_nxt;
            r_out_last  <= w_out_last_nxt;
            r_pos       <= w_pos_nxt;
            r_part      <= w_part_nxt;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_last  = r_out_last;
    assign busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_requant_packer.sv
`default_nettype none
// ============================================================================
// Module      : tb_requant_packer
// Description : Directed self-checking bench for requant_packer. Output bytes
//               are collected as {out_last, out_data} and compared against
//               hand-computed values.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_requant_packer;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  prec;
    logic [15:0] scale_m;
    logic [4:0]  shift;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_acc;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        out_last;
    logic        busy;
    logic [15:0] sat_count;

    int n_cmp = 0;
    int n_err = 0;

`ifdef REQUANT_SAT_CNT_EN
    localparam bit c_sat_en = 1'b1;
`else
    localparam bit c_sat_en = 1'b0;
`endif

    requant_packer u_dut (
        .clk       (clk),
        .rst       (rst),
        .prec      (prec),
        .scale_m   (scale_m),
        .shift     (shift),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_acc    (in_acc),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy),
        .sat_count (sat_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Output monitor: collects accepted bytes and checks stall stability.
    logic [8:0] q[$];
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data  = 8'h00;
    logic       prev_last  = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall)
                check("stall_hold", 32'({out_valid, out_last, out_data}),
                      32'({1'b1, prev_last, prev_data}));
            if (out_valid && out_ready)
                q.push_back({out_last, out_data});
            prev_stall <= out_valid && !out_ready;
            prev_data  <= out_data;
            prev_last  <= out_last;
        end
    end

    // Drive one element and hold it until accepted (called just after posedge).
    task automatic send(input int a, input logic l);
        logic rdy;
        int   g;
        g        = 0;
        in_valid = 1'b1;
        in_acc   = a;
        in_last  = l;
        forever begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            #1;
            if (rdy) break;
            g++;
            if (g > 50) begin
                check("send_timeout", 32'd0, 32'd1);
                break;
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Wait for n bytes, let the pipe drain, then confirm nothing extra appeared.
    task automatic wait_bytes(input int n, input string tag);
        int g;
        g = 0;
        while ((q.size() < n) && (g < 200)) begin
            @(posedge clk);
            g++;
        end
        repeat (4) @(posedge clk);
        #1;
        check(tag, 32'(q.size()), 32'(n));
    endtask

    task automatic check_byte(input string tag, input int idx, input logic [8:0] exp);
        if (idx < q.size()) check(tag, 32'(q[idx]), 32'(exp));
        else                check(tag, 32'hDEAD, 32'(exp));
    endtask

    logic lat0, lat1, lat2, busy_mid, rdy_stall;
    int   nv;

    initial begin
        rst       = 1'b1;
        prec      = 2'd0;
        scale_m   = 16'd1;
        shift     = 5'd0;
        in_valid  = 1'b0;
        in_acc    = 32'd0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state, first cycle after reset
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data",  32'(out_data),  32'd0);
        check("rst_out_last",  32'(out_last),  32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_sat",       32'(sat_count), 32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        @(posedge clk);
        #1;

        // 1: INT8 saturation both ways plus latency (valid in 3rd cycle after accept)
        q.delete();
        send(300, 1'b0);
        fork
            begin
                send(-200, 1'b0);
                send(5, 1'b1);
            end
            begin
                @(negedge clk); lat0 = out_valid; busy_mid = busy;
                @(negedge clk); lat1 = out_valid;
                @(negedge clk); lat2 = out_valid;
            end
        join
        check("t1_lat_c1", 32'(lat0), 32'd0);
        check("t1_lat_c2", 32'(lat1), 32'd0);
        check("t1_lat_c3", 32'(lat2), 32'd1);
        check("t1_busy_mid", 32'(busy_mid), 32'd1);
        wait_bytes(3, "t1_count");
        check_byte("t1_b0", 0, 9'h07F);
        check_byte("t1_b1", 1, 9'h080);
        check_byte("t1_b2", 2, 9'h105);
        check("t1_busy_end", 32'(busy), 32'd0);
        check("t1_sat", 32'(sat_count), c_sat_en ? 32'd2 : 32'd0);

        // 2: INT8 scale 3 shift 2; config changes mid-packet must be ignored
        q.delete();
        prec = 2'd0; scale_m = 16'd3; shift = 5'd2;
        send(5, 1'b0);
        prec = 2'd1; scale_m = 16'd100; shift = 5'd0;
        send(-5, 1'b1);
        wait_bytes(2, "t2_count");
        check_byte("t2_b0", 0, 9'h004);
        check_byte("t2_b1", 1, 9'h1FC);
        check("t2_sat", 32'(sat_count), c_sat_en ? 32'd2 : 32'd0);

        // 3: INT4 nibble packing, 9 clamps to 7, partial final byte
        q.delete();
        prec = 2'd1; scale_m = 16'd1; shift = 5'd0;
        send(3, 1'b0);
        send(-2, 1'b0);
        send(9, 1'b1);
        wait_bytes(2, "t3_count");
        check_byte("t3_b0", 0, 9'h0E3);
        check_byte("t3_b1", 1, 9'h107);
        check("t3_sat", 32'(sat_count), c_sat_en ? 32'd3 : 32'd0);

        // 4: BIN, LSB first, code 3 also selects BIN
        q.delete();
        prec = 2'd3;
        send(1, 1'b0);  send(-1, 1'b0); send(-1, 1'b0); send(1, 1'b0);
        send(0, 1'b0);  send(-3, 1'b0); send(2, 1'b0);  send(-1, 1'b0);
        send(5, 1'b1);
        wait_bytes(2, "t4_count");
        check_byte("t4_b0", 0, 9'h059);
        check_byte("t4_b1", 1, 9'h101);
        check("t4_sat", 32'(sat_count), c_sat_en ? 32'd3 : 32'd0);

        // 5: 16-element INT8 stream with a 5-cycle output stall mid-stream
        q.delete();
        prec = 2'd0; scale_m = 16'd1; shift = 5'd0;
        fork
            begin
                for (int i = 0; i < 16; i++) send(i * 7 - 50, i == 15);
            end
            begin
                repeat (6) @(posedge clk);
                #1;
                out_ready = 1'b0;
                @(negedge clk);
                @(negedge clk);
                rdy_stall = in_ready;
                repeat (4) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        check("t5_in_ready_stall", 32'(rdy_stall), 32'd0);
        wait_bytes(16, "t5_count");
        for (int i = 0; i < 16; i++) begin
            logic [7:0] e;
            e = 8'(i * 7 - 50);
            check_byte($sformatf("t5_b%0d", i), i, {(i == 15), e});
        end

        // 6: reset in mid-packet discards the element, next packet is clean
        q.delete();
        prec = 2'd1;
        send(3, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_in_ready", 32'(in_ready), 32'd1);
        check("t6_sat", 32'(sat_count), 32'd0);
        nv = 0;
        for (int i = 0; i < 6; i++) begin
            if (out_valid) nv++;
            @(negedge clk);
        end
        check("t6_no_valid", 32'(nv), 32'd0);
        @(posedge clk);
        #1;
        send(4, 1'b0);
        send(5, 1'b1);
        wait_bytes(1, "t6_count");
        check_byte("t6_b0", 0, 9'h154);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
